uart_rx_push: RTL and testbench
===============================

Name: uart_rx_push

Overview:
- UART receive front end that deserializes the serial line `uart_rx` (8N1, LSB first) into bytes.
- Each received byte goes into a one-byte holding register.
- The holding register is pushed into the receive ring buffer (`cycle_reg` write side) via the `i_order`/`i_data`/`i_done` handshake.
- Sits between the board pin and the receive `cycle_reg` inside `uart_manage`. The shift register and the push side run concurrently, so a new frame can arrive while the previous byte is still waiting on a full buffer.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per bit period (100 MHz / 115200); must be >= 4.
- SYNC_STAGES, 2, flip-flop stages synchronizing uart_rx; must be >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rstn  input  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- uart_rx  input  1  serial line, idle high, asynchronous to clk.
- i_order  output  1  write request to ring buffer, one-cycle pulses only.
- i_data  output  8  byte presented with i_order.
- i_done  input  1  ring buffer acceptance, high the cycle after an accepted i_order.
- busy  output  1  high while a frame is in progress or the holding register is full.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte completed while holding register full.

Behaviour:
- Reset (async, rstn=0):
  - Synchronizer flops = 1.
  - Rx FSM = IDLE; push FSM = EMPTY.
  - i_order=0, i_data=8'h00, busy=0, frame_err=0, overrun=0.
  - Counters cleared.
  - Reset mid-frame or mid-push discards all state; no partial push after release.
- Sampled line `rxs` = last synchronizer stage; all decisions use rxs only.
- Rx FSM (bit counter 0..CLKS_PER_BIT-1, bit index 0..7):
  - IDLE: on rxs=0 go START and load counter.
  - START: at CLKS_PER_BIT/2 (integer division) cycles, re-sample rxs.
    - 0: go DATA and restart counter.
    - 1: glitch; return to IDLE with no pulse.
  - DATA: every CLKS_PER_BIT cycles sample rxs into shift[bit_index], LSB first. After bit 7 go STOP.
  - STOP: after CLKS_PER_BIT cycles sample rxs.
    - 1: byte complete; hand to push side (below); go IDLE.
    - 0: pulse frame_err, drop byte, go BREAK.
  - BREAK: wait for rxs=1, then IDLE. A held-low line yields exactly one frame_err.
- Hand-off on byte complete:
  - Push FSM EMPTY: load i_data, go REQ in the same edge.
  - Otherwise: pulse overrun and drop the new byte; the old byte is kept.
- Push FSM:
  - EMPTY: i_order=0.
  - REQ: i_order=1 for exactly one cycle, then go WAIT.
  - WAIT: i_order=0. Sample i_done.
    - 1: go EMPTY.
    - 0: ring buffer full; go REQ and retry next cycle.
  - i_order is never high on two consecutive cycles. This is required because `cycle_reg` writes on every cycle `i_order` is high.
- i_data is stable from entry to REQ until return to EMPTY.
- busy = (rx FSM != IDLE) | (push FSM != EMPTY), registered.
- Latency: i_order rises 1 cycle after the stop-bit sample edge. With the buffer not full, EMPTY is re-entered 2 cycles later.
- Simultaneous events:
  - Byte complete in the same cycle WAIT sees i_done=1: the holding register counts as full, so overrun fires.
  - frame_err and overrun never pulse in the same cycle.

Optional Feature:
- Macro UART_RX_ERR_CNT_EN.
- Defined:
  - Adds output err_cnt (16 bits) = {frame_cnt[7:0], overrun_cnt[7:0]}.
  - Each 8-bit counter saturates at 8'hFF.
  - Each increments on its pulse; both cleared by reset only.
- Undefined: port and counters absent; all other behaviour identical.

Test Plan:
- All tests use CLKS_PER_BIT=16.
- Frame 0x55, buffer always accepting (i_done=1 the cycle after i_order) -> one i_order pulse with i_data=8'h55, busy returns low, no error pulses.
- Glitch on uart_rx low for 4 cycles -> no i_order, no frame_err, Rx FSM back to IDLE.
- Frame 0xA3 with stop bit low, then line held low 100 cycles, then high -> exactly one frame_err pulse, no i_order; a following 0x3C frame is pushed correctly.
- Buffer full (i_done=0) for 50 cycles after frame 0x12 -> i_order pulses every other cycle with i_data=8'h12. When i_done=1 is returned, pushing stops; exactly one accepted write.
- Buffer full while frames 0x12 then 0x34 arrive -> overrun pulses once; the byte eventually pushed is 8'h12. With UART_RX_ERR_CNT_EN, err_cnt=16'h0001.
- Assert rstn low mid-DATA of frame 0x77 and mid-WAIT -> all outputs at reset values immediately; after release, no i_order until a fresh frame completes.

Source files
------------

// File: rtl/uart_rx_push.sv
// UART 8N1 receiver with a one-byte holding register pushed into the receive ring buffer.
// Optional build macro UART_RX_ERR_CNT_EN adds saturating frame-error/overrun counters on err_cnt.
module uart_rx_push #(
  parameter int CLKS_PER_BIT = 868,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       uart_rx,
  output logic       i_order,
  output logic [7:0] i_data,
  input  logic       i_done,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
`ifdef UART_RX_ERR_CNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  typedef enum logic [1:0] {
    PS_EMPTY,
    PS_REQ,
    PS_WAIT
  } push_state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rxs;

  rx_state_t   r_rx_state, w_rx_next;
  push_state_t r_push_state, w_push_next;

  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [2:0]       r_bit_idx, w_bit_idx_next;
  logic [7:0]       r_shift, w_shift_next;
  logic [7:0]       r_data, w_data_next;
  logic             w_byte_done;
  logic             w_frame_err_next;
  logic             w_overrun_next;

  logic r_order;
  logic r_busy;
  logic r_frame_err;
  logic r_overrun;

  assign w_rxs = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], uart_rx};
    end
  end

  always_comb begin
    w_rx_next        = r_rx_state;
    w_cnt_next       = r_cnt + 1'b1;
    w_bit_idx_next   = r_bit_idx;
    w_shift_next     = r_shift;
    w_byte_done      = 1'b0;
    w_frame_err_next = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        w_cnt_next     = '0;
        w_bit_idx_next = 3'd0;
        if (!w_rxs) w_rx_next = RX_START;
      end
      RX_START: begin
        // Mid-start-bit check rejects short glitches on the line.
        if (r_cnt == HALF_CNT) begin
          w_cnt_next = '0;
          w_rx_next  = w_rxs ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_cnt == LAST_CNT) begin
          w_cnt_next              = '0;
          w_shift_next[r_bit_idx] = w_rxs;
          w_bit_idx_next          = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_rx_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_cnt == LAST_CNT) begin
          w_cnt_next = '0;
          if (w_rxs) begin
            w_byte_done = 1'b1;
            w_rx_next   = RX_IDLE;
          end else begin
            w_frame_err_next = 1'b1;
            w_rx_next        = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        w_cnt_next = '0;
        if (w_rxs) w_rx_next = RX_IDLE;
      end
      default: begin
        w_cnt_next = '0;
        w_rx_next  = RX_IDLE;
      end
    endcase
  end

  // WAIT bounces back to REQ on a full buffer, so i_order can never pulse twice in a row.
  always_comb begin
    w_push_next    = r_push_state;
    w_data_next    = r_data;
    w_overrun_next = w_byte_done && (r_push_state != PS_EMPTY);
    case (r_push_state)
      PS_EMPTY: begin
        if (w_byte_done) begin
          w_data_next = r_shift;
          w_push_next = PS_REQ;
        end
      end
      PS_REQ:  w_push_next = PS_WAIT;
      PS_WAIT: w_push_next = i_done ? PS_EMPTY : PS_REQ;
      default: w_push_next = PS_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rx_state   <= RX_IDLE;
      r_push_state <= PS_EMPTY;
      r_cnt        <= '0;
      r_bit_idx    <= 3'd0;
      r_shift      <= 8'h00;
      r_data       <= 8'h00;
      r_order      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_rx_state   <= w_rx_next;
      r_push_state <= w_push_next;
      r_cnt        <= w_cnt_next;
      r_bit_idx    <= w_bit_idx_next;
      r_shift      <= w_shift_next;
      r_data       <= w_data_next;
      r_order      <= (w_push_next == PS_REQ);
      r_busy       <= (w_rx_next != RX_IDLE) || (w_push_next != PS_EMPTY);
      r_frame_err  <= w_frame_err_next;
      r_overrun    <= w_overrun_next;
    end
  end

  assign i_order   = r_order;
  assign i_data    = r_data;
  assign busy      = r_busy;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] r_frame_cnt;
  logic [7:0] r_overrun_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_frame_cnt   <= 8'h00;
      r_overrun_cnt <= 8'h00;
    end else begin
      if (r_frame_err && (r_frame_cnt != 8'hFF)) r_frame_cnt <= r_frame_cnt + 8'd1;
      if (r_overrun && (r_overrun_cnt != 8'hFF)) r_overrun_cnt <= r_overrun_cnt + 8'd1;
    end
  end

  assign err_cnt = {r_frame_cnt, r_overrun_cnt};
`endif

endmodule

// File: tb/tb_uart_rx_push.sv
// Self-checking bench for uart_rx_push: a ring-buffer responder model plus a scoreboard of expected
// accepted bytes, with one task per scenario.
module tb_uart_rx_push;

  localparam int CPB = 16;

  logic       clk;
  logic       rstn;
  logic       uartRx;
  logic       iOrder;
  logic [7:0] iData;
  logic       iDone;
  logic       busy;
  logic       frameErr;
  logic       overrun;
`ifdef UART_RX_ERR_CNT_EN
  logic [15:0] errCnt;
`endif

  logic acceptMode;

  int checks = 0;
  int errors = 0;

  int orderCnt    = 0;
  int acceptCnt   = 0;
  int frameErrCnt = 0;
  int overrunCnt  = 0;
  int consecCnt   = 0;
  int coincCnt    = 0;
  logic prevOrder = 1'b0;
  logic [7:0] acceptQ[$];
  logic [7:0] orderQ[$];

  logic [7:0] expQ[$];
  int rdIdx = 0;

  uart_rx_push #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .uart_rx  (uartRx),
    .i_order  (iOrder),
    .i_data   (iData),
    .i_done   (iDone),
    .busy     (busy),
    .frame_err(frameErr),
    .overrun  (overrun)
`ifdef UART_RX_ERR_CNT_EN
    ,
    .err_cnt  (errCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ring buffer model: acknowledges the cycle after a request when it has room.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) iDone <= 1'b0;
    else iDone <= iOrder && acceptMode;
  end

  // Monitor sampling on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (iOrder) begin
      orderCnt <= orderCnt + 1;
      orderQ.push_back(iData);
      if (acceptMode) begin
        acceptCnt <= acceptCnt + 1;
        acceptQ.push_back(iData);
      end
    end
    if (iOrder && prevOrder) consecCnt <= consecCnt + 1;
    prevOrder <= iOrder;
    if (frameErr) frameErrCnt <= frameErrCnt + 1;
    if (overrun) overrunCnt <= overrunCnt + 1;
    if (frameErr && overrun) coincCnt <= coincCnt + 1;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic stopBit);
    uartRx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uartRx = d[i];
      tick(CPB);
    end
    uartRx = stopBit;
    tick(CPB);
  endtask

  task automatic waitIdle(input int maxCycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxCycles; i++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    uartRx = 1'b1;
    acceptMode = 1'b1;
    tick(3);
    checks++;
    if ({iOrder, iData, busy, frameErr, overrun} !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %h want 000", {iOrder, iData, busy, frameErr, overrun});
    end
    rstn = 1'b1;
    tick(5);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_busy got %b want 0", busy);
    end
  endtask

  task automatic test_basic();
    int a0 = acceptCnt, f0 = frameErrCnt, v0 = overrunCnt;
    bit ok;
    logic [7:0] exp, got;
    expQ.push_back(8'h55);
    sendFrame(8'h55, 1'b1);
    waitIdle(60, ok);
    tick(2);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL basic_idle busy got %b want 0", busy);
    end
    checks++;
    if (acceptCnt - a0 != 1) begin
      errors++;
      $display("[TB] FAIL basic_writes got %0d want 1", acceptCnt - a0);
    end
    exp = expQ.pop_front();
    got = (acceptQ.size() > rdIdx) ? acceptQ[rdIdx] : 8'hxx;
    rdIdx = acceptQ.size();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL basic_data got %h want %h", got, exp);
    end
    checks++;
    if ((frameErrCnt - f0) + (overrunCnt - v0) != 0) begin
      errors++;
      $display("[TB] FAIL basic_errpulses got %0d want 0", (frameErrCnt - f0) + (overrunCnt - v0));
    end
  endtask

  task automatic test_glitch();
    int o0 = orderCnt, f0 = frameErrCnt;
    uartRx = 1'b0;
    tick(4);
    uartRx = 1'b1;
    tick(30);
    checks++;
    if (orderCnt - o0 != 0 || frameErrCnt - f0 != 0) begin
      errors++;
      $display("[TB] FAIL glitch_pulses got order %0d ferr %0d want 0 0", orderCnt - o0, frameErrCnt - f0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL glitch_idle busy got %b want 0", busy);
    end
  endtask

  task automatic test_frame_error();
    int o0 = orderCnt, f0 = frameErrCnt, a0;
    bit ok;
    logic [7:0] exp, got;
    sendFrame(8'hA3, 1'b0);
    tick(100);
    uartRx = 1'b1;
    tick(20);
    checks++;
    if (frameErrCnt - f0 != 1) begin
      errors++;
      $display("[TB] FAIL ferr_count got %0d want 1", frameErrCnt - f0);
    end
    checks++;
    if (orderCnt - o0 != 0) begin
      errors++;
      $display("[TB] FAIL ferr_noorder got %0d want 0", orderCnt - o0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ferr_idle busy got %b want 0", busy);
    end
    a0 = acceptCnt;
    expQ.push_back(8'h3C);
    sendFrame(8'h3C, 1'b1);
    waitIdle(60, ok);
    tick(2);
    checks++;
    if (!ok || acceptCnt - a0 != 1) begin
      errors++;
      $display("[TB] FAIL ferr_next_writes got %0d idle %b want 1 1", acceptCnt - a0, ok);
    end
    exp = expQ.pop_front();
    got = (acceptQ.size() > rdIdx) ? acceptQ[rdIdx] : 8'hxx;
    rdIdx = acceptQ.size();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL ferr_next_data got %h want %h", got, exp);
    end
  endtask

  task automatic test_buffer_full();
    int o0 = orderCnt, a0 = acceptCnt, c0 = consecCnt, q0 = orderQ.size(), n, bad, o1;
    bit ok;
    logic [7:0] exp, got;
    acceptMode = 1'b0;
    sendFrame(8'h12, 1'b1);
    tick(50);
    n = orderCnt - o0;
    checks++;
    if (n < 25 || n > 31) begin
      errors++;
      $display("[TB] FAIL full_retries got %0d want 25..31", n);
    end
    checks++;
    if (consecCnt - c0 != 0) begin
      errors++;
      $display("[TB] FAIL full_consecutive got %0d want 0", consecCnt - c0);
    end
    bad = 0;
    for (int i = q0; i < orderQ.size(); i++) if (orderQ[i] !== 8'h12) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL full_retry_data got %0d wrong bytes want 0", bad);
    end
    checks++;
    if (acceptCnt - a0 != 0) begin
      errors++;
      $display("[TB] FAIL full_noaccept got %0d want 0", acceptCnt - a0);
    end
    expQ.push_back(8'h12);
    acceptMode = 1'b1;
    waitIdle(20, ok);
    o1 = orderCnt;
    tick(20);
    checks++;
    if (!ok || acceptCnt - a0 != 1) begin
      errors++;
      $display("[TB] FAIL full_accept got %0d idle %b want 1 1", acceptCnt - a0, ok);
    end
    checks++;
    if (orderCnt != o1) begin
      errors++;
      $display("[TB] FAIL full_stop got %0d extra orders want 0", orderCnt - o1);
    end
    exp = expQ.pop_front();
    got = (acceptQ.size() > rdIdx) ? acceptQ[rdIdx] : 8'hxx;
    rdIdx = acceptQ.size();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL full_data got %h want %h", got, exp);
    end
  endtask

  task automatic test_overrun();
    int a0, v0, f0;
    bit ok;
    logic [7:0] exp, got;
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
    tick(2);
    a0 = acceptCnt;
    v0 = overrunCnt;
    f0 = frameErrCnt;
    acceptMode = 1'b0;
    sendFrame(8'h12, 1'b1);
    sendFrame(8'h34, 1'b1);
    tick(10);
    checks++;
    if (overrunCnt - v0 != 1 || frameErrCnt - f0 != 0) begin
      errors++;
      $display("[TB] FAIL ovr_pulses got ovr %0d ferr %0d want 1 0", overrunCnt - v0, frameErrCnt - f0);
    end
`ifdef UART_RX_ERR_CNT_EN
    checks++;
    if (errCnt !== 16'h0001) begin
      errors++;
      $display("[TB] FAIL ovr_errcnt got %h want 0001", errCnt);
    end
`endif
    expQ.push_back(8'h12);
    acceptMode = 1'b1;
    waitIdle(20, ok);
    tick(2);
    checks++;
    if (!ok || acceptCnt - a0 != 1) begin
      errors++;
      $display("[TB] FAIL ovr_accept got %0d idle %b want 1 1", acceptCnt - a0, ok);
    end
    exp = expQ.pop_front();
    got = (acceptQ.size() > rdIdx) ? acceptQ[rdIdx] : 8'hxx;
    rdIdx = acceptQ.size();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL ovr_data got %h want %h", got, exp);
    end
  endtask

  task automatic test_reset_midflight();
    int o0, a0;
    bit ok, seen;
    logic [7:0] exp, got;
    logic [7:0] d77;
    d77 = 8'h77;
    uartRx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      uartRx = d77[i];
      tick(CPB);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_data_busy got %b want 1", busy);
    end
    rstn = 1'b0;
    uartRx = 1'b1;
    #1;
    checks++;
    if ({iOrder, iData, busy, frameErr, overrun} !== 12'h000) begin
      errors++;
      $display("[TB] FAIL mid_data_reset got %h want 000", {iOrder, iData, busy, frameErr, overrun});
    end
    tick(2);
    rstn = 1'b1;
    o0 = orderCnt;
    tick(60);
    checks++;
    if (orderCnt - o0 != 0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_data_after got orders %0d busy %b want 0 0", orderCnt - o0, busy);
    end

    acceptMode = 1'b0;
    sendFrame(8'h77, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (iOrder === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick(1);
    end
    tick(1);
    checks++;
    if (!seen || iData !== 8'h77 || iOrder !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_wait_setup got seen %b data %h order %b want 1 77 0", seen, iData, iOrder);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({iOrder, iData, busy, frameErr, overrun} !== 12'h000) begin
      errors++;
      $display("[TB] FAIL mid_wait_reset got %h want 000", {iOrder, iData, busy, frameErr, overrun});
    end
    tick(2);
    rstn = 1'b1;
    acceptMode = 1'b1;
    o0 = orderCnt;
    tick(40);
    checks++;
    if (orderCnt - o0 != 0) begin
      errors++;
      $display("[TB] FAIL mid_wait_after got %0d orders want 0", orderCnt - o0);
    end
    rdIdx = acceptQ.size();
    a0 = acceptCnt;
    expQ.push_back(8'h5A);
    sendFrame(8'h5A, 1'b1);
    waitIdle(60, ok);
    tick(2);
    checks++;
    if (!ok || acceptCnt - a0 != 1) begin
      errors++;
      $display("[TB] FAIL fresh_writes got %0d idle %b want 1 1", acceptCnt - a0, ok);
    end
    exp = expQ.pop_front();
    got = (acceptQ.size() > rdIdx) ? acceptQ[rdIdx] : 8'hxx;
    rdIdx = acceptQ.size();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL fresh_data got %h want %h", got, exp);
    end
  endtask

  initial begin
    rstn = 1'b0;
    uartRx = 1'b1;
    acceptMode = 1'b1;
    test_reset();
    test_basic();
    test_glitch();
    test_frame_error();
    test_buffer_full();
    test_overrun();
    test_reset_midflight();
    checks++;
    if (consecCnt != 0) begin
      errors++;
      $display("[TB] FAIL order_back_to_back got %0d want 0", consecCnt);
    end
    checks++;
    if (coincCnt != 0) begin
      errors++;
      $display("[TB] FAIL ferr_ovr_same_cycle got %0d want 0", coincCnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
